// File: rtl/j_mtxarb_pkg.sv
// Shared definitions for the three-requester RAM arbiter: FSM states,
// RAM data-mux select codes, starvation threshold and address width.
package j_mtxarb_pkg;

  localparam int ADDR_W = 10;

  // gpu is forced through once it has lost this many arbitration rounds
  localparam logic [2:0] STARVE_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_MTX  = 2'd1,
    SEL_GPU  = 2'd2,
    SEL_EXT  = 2'd3
  } sel_e;

endpackage

// File: rtl/j_mtxarb_pick.sv
// Combinational eligibility and priority picker; returns the ram_sel code
// of the requester that would win if arbitration happened this cycle.
module j_mtxarb_pick
  import j_mtxarb_pkg::*;
(
  input  logic       mtx_req_i,
  input  logic       gpu_req_i,
  input  logic       ext_req_i,
  input  logic       atomic_i,
  input  logic [2:0] starve_i,
  output logic [1:0] grant_o
);

  // An atomic matrix sequence shuts everyone else out, including a starved gpu.
  always_comb begin
    grant_o = SEL_NONE;
    if (atomic_i) begin
      if (mtx_req_i) begin
        grant_o = SEL_MTX;
      end
    end else if (gpu_req_i && (starve_i >= STARVE_MAX)) begin
      grant_o = SEL_GPU;
    end else if (ext_req_i) begin
      grant_o = SEL_EXT;
    end else if (mtx_req_i) begin
      grant_o = SEL_MTX;
    end else if (gpu_req_i) begin
      grant_o = SEL_GPU;
    end
  end

endmodule

// File: rtl/j_mtxarb.sv
// Single-port RAM arbiter between matrix fetch, GPU load/store and the
// external bus, with programmable wait states and gpu starvation relief.
module j_mtxarb
  import j_mtxarb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,

  input  logic              mtx_mreq,
  input  logic              mtx_atomic,
  input  logic [ADDR_W-1:0] mtx_addr,
  output logic              mtx_datack,

  input  logic              gpu_mreq,
  input  logic              gpu_wr,
  input  logic [ADDR_W-1:0] gpu_addr,
  output logic              gpu_datack,

  input  logic              ext_mreq,
  input  logic              ext_wr,
  input  logic [ADDR_W-1:0] ext_addr,
  output logic              ext_datack,

  input  logic              cfg_wr,
  input  logic [1:0]        cfg_din,

  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_sel,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic [2:0]        starve_q, starve_d;
  logic [1:0]        grant;

  j_mtxarb_pick u_pick (
    .mtx_req_i (mtx_mreq),
    .gpu_req_i (gpu_mreq),
    .ext_req_i (ext_mreq),
    .atomic_i  (mtx_atomic),
    .starve_i  (starve_q),
    .grant_o   (grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= 2'd0;
      wait_q   <= 2'd0;
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  // The wait register updates independently of the FSM; a grant in the same
  // cycle as cfg_wr copies the old wait_q into cnt, so in-flight W is fixed.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    wait_d   = cfg_wr ? cfg_din : wait_q;

    case (state_q)
      ST_IDLE: begin
        if (gpu_mreq && (grant != SEL_GPU)) begin
          starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 3'd1;
        end else begin
          starve_d = 3'd0;
        end

        if (grant != SEL_NONE) begin
          state_d = ST_ACCESS;
          sel_d   = grant;
          cnt_d   = wait_q;
          case (grant)
            SEL_EXT: begin
              addr_d = ext_addr;
              we_d   = ext_wr;
            end
            SEL_GPU: begin
              addr_d = gpu_addr;
              we_d   = gpu_wr;
            end
            default: begin
              addr_d = mtx_addr;
              we_d   = 1'b0;
            end
          endcase
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
        addr_d  = '0;
        we_d    = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_cs     = (state_q == ST_ACCESS);
  assign ram_we     = ram_cs && we_q;
  assign ram_addr   = addr_q;
  assign ram_sel    = sel_q;
  assign busy       = (state_q != ST_IDLE);
  assign mtx_datack = (state_q == ST_ACK) && (sel_q == SEL_MTX);
  assign gpu_datack = (state_q == ST_ACK) && (sel_q == SEL_GPU);
  assign ext_datack = (state_q == ST_ACK) && (sel_q == SEL_EXT);

endmodule

// File: tb/tb_j_mtxarb.sv
// Directed self-checking bench for j_mtxarb: reset, single access, wait
// states, priority, atomic lock, starvation, mid-access reset, cfg collision.
module tb_j_mtxarb;

  logic       clk;
  logic       reset_n;
  logic       mtx_mreq, mtx_atomic, mtx_datack;
  logic [9:0] mtx_addr;
  logic       gpu_mreq, gpu_wr, gpu_datack;
  logic [9:0] gpu_addr;
  logic       ext_mreq, ext_wr, ext_datack;
  logic [9:0] ext_addr;
  logic       cfg_wr;
  logic [1:0] cfg_din;
  logic       ram_cs, ram_we, busy;
  logic [9:0] ram_addr;
  logic [1:0] ram_sel;

  int checkCount = 0;
  int failCount  = 0;

  j_mtxarb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mtx_mreq   (mtx_mreq),
    .mtx_atomic (mtx_atomic),
    .mtx_addr   (mtx_addr),
    .mtx_datack (mtx_datack),
    .gpu_mreq   (gpu_mreq),
    .gpu_wr     (gpu_wr),
    .gpu_addr   (gpu_addr),
    .gpu_datack (gpu_datack),
    .ext_mreq   (ext_mreq),
    .ext_wr     (ext_wr),
    .ext_addr   (ext_addr),
    .ext_datack (ext_datack),
    .cfg_wr     (cfg_wr),
    .cfg_din    (cfg_din),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_sel    (ram_sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bench "cycle" begins 1ns after a rising edge; inputs set here are
  // sampled at the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset_n    = 1'b0;
    mtx_mreq   = 1'b0;
    mtx_atomic = 1'b0;
    mtx_addr   = '0;
    gpu_mreq   = 1'b0;
    gpu_wr     = 1'b0;
    gpu_addr   = '0;
    ext_mreq   = 1'b0;
    ext_wr     = 1'b0;
    ext_addr   = '0;
    cfg_wr     = 1'b0;
    cfg_din    = 2'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    applyReset();
    reset_n = 1'b0;
    #1;
    outs = {mtx_datack, gpu_datack, ext_datack, ram_cs, ram_we, busy, |ram_sel};
    checkCount++;
    if (outs !== 7'b0) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000", outs);
    end
    checkCount++;
    if (ram_addr !== 10'h000) begin
      failCount++;
      $display("[TB] FAIL reset_addr: got %h expected 000", ram_addr);
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    applyReset();
    gpu_mreq = 1'b1;
    gpu_wr   = 1'b0;
    gpu_addr = 10'h155;
    step();
    checkCount++;
    if ({ram_cs, ram_we, ram_sel, gpu_datack} !== {1'b1, 1'b0, 2'd2, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_access: cs/we/sel/ack got %b expected 10100",
               {ram_cs, ram_we, ram_sel, gpu_datack});
    end
    checkCount++;
    if (ram_addr !== 10'h155) begin
      failCount++;
      $display("[TB] FAIL single_addr: got %h expected 155", ram_addr);
    end
    step();
    checkCount++;
    if ({gpu_datack, mtx_datack, ext_datack, ram_cs, ram_addr} !== {4'b1000, 10'h155}) begin
      failCount++;
      $display("[TB] FAIL single_ack: ack g/m/e cs addr got %b %h expected 1000 155",
               {gpu_datack, mtx_datack, ext_datack, ram_cs}, ram_addr);
    end
    gpu_mreq = 1'b0;
    step();
    checkCount++;
    if ({gpu_datack, busy} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL single_after: ack/busy got %b expected 00", {gpu_datack, busy});
    end
  endtask

  task automatic test_wait_states();
    applyReset();
    cfg_wr  = 1'b1;
    cfg_din = 2'd3;
    step();
    cfg_wr   = 1'b0;
    ext_mreq = 1'b1;
    ext_wr   = 1'b1;
    ext_addr = 10'h2AA;
    for (int i = 1; i <= 4; i++) begin
      step();
      checkCount++;
      if ({ram_cs, ram_we, ext_datack, ram_sel} !== {3'b110, 2'd3}) begin
        failCount++;
        $display("[TB] FAIL wait_access[%0d]: cs/we/ack/sel got %b expected 11011",
                 i, {ram_cs, ram_we, ext_datack, ram_sel});
      end
    end
    step();
    checkCount++;
    if ({ext_datack, ram_cs} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL wait_ack: ack/cs got %b expected 10", {ext_datack, ram_cs});
    end
    ext_mreq = 1'b0;
    step();
  endtask

  task automatic test_priority();
    applyReset();
    mtx_mreq = 1'b1;
    mtx_addr = 10'h0F0;
    gpu_mreq = 1'b1;
    gpu_wr   = 1'b1;
    gpu_addr = 10'h00F;
    step();
    checkCount++;
    if ({ram_sel, ram_we, ram_addr} !== {2'd1, 1'b0, 10'h0F0}) begin
      failCount++;
      $display("[TB] FAIL prio_mtx: sel/we/addr got %0d %b %h expected 1 0 0f0",
               ram_sel, ram_we, ram_addr);
    end
    step();
    mtx_mreq = 1'b0;
    step();
    step();
    checkCount++;
    if ({ram_sel, ram_we, ram_addr} !== {2'd2, 1'b1, 10'h00F}) begin
      failCount++;
      $display("[TB] FAIL prio_gpu: sel/we/addr got %0d %b %h expected 2 1 00f",
               ram_sel, ram_we, ram_addr);
    end
    gpu_mreq = 1'b0;
    step();
    step();
  endtask

  task automatic test_atomic();
    int mtxAcks = 0;
    int othAcks = 0;
    int gotOther;
    applyReset();
    mtx_atomic = 1'b1;
    mtx_mreq   = 1'b1;
    gpu_mreq   = 1'b1;
    ext_mreq   = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      if (mtx_datack) mtxAcks++;
      if (gpu_datack || ext_datack) othAcks++;
    end
    checkCount++;
    if (mtxAcks != 3) begin
      failCount++;
      $display("[TB] FAIL atomic_mtx_acks: got %0d expected 3", mtxAcks);
    end
    checkCount++;
    if (othAcks != 0) begin
      failCount++;
      $display("[TB] FAIL atomic_other_acks: got %0d expected 0", othAcks);
    end
    mtx_atomic = 1'b0;
    mtx_mreq   = 1'b0;
    gotOther   = 0;
    for (int c = 0; c < 12 && gotOther == 0; c++) begin
      step();
      if (gpu_datack || ext_datack) gotOther = 1;
    end
    checkCount++;
    if (gotOther != 1) begin
      failCount++;
      $display("[TB] FAIL atomic_release: other ack got %0d expected 1", gotOther);
    end
    gpu_mreq = 1'b0;
    ext_mreq = 1'b0;
    step();
    step();
  endtask

  task automatic test_starvation();
    int order [6];
    int expOrder [6];
    int n = 0;
    int multi = 0;
    expOrder = '{3, 3, 3, 3, 2, 3};
    applyReset();
    ext_mreq = 1'b1;
    gpu_mreq = 1'b1;
    for (int c = 0; c < 60 && n < 6; c++) begin
      step();
      if ($countones({mtx_datack, gpu_datack, ext_datack}) > 1) multi++;
      if (ext_datack) begin
        order[n] = 3;
        n++;
      end else if (gpu_datack) begin
        order[n] = 2;
        n++;
      end else if (mtx_datack) begin
        order[n] = 1;
        n++;
      end
    end
    checkCount++;
    if (n != 6) begin
      failCount++;
      $display("[TB] FAIL starve_timeout: acks got %0d expected 6", n);
    end
    for (int i = 0; i < n; i++) begin
      checkCount++;
      if (order[i] != expOrder[i]) begin
        failCount++;
        $display("[TB] FAIL starve_order[%0d]: sel got %0d expected %0d", i, order[i], expOrder[i]);
      end
    end
    checkCount++;
    if (multi != 0) begin
      failCount++;
      $display("[TB] FAIL starve_onehot: multi-ack cycles got %0d expected 0", multi);
    end
    ext_mreq = 1'b0;
    gpu_mreq = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    logic [6:0] outs;
    int acks = 0;
    applyReset();
    cfg_wr  = 1'b1;
    cfg_din = 2'd2;
    step();
    cfg_wr   = 1'b0;
    mtx_mreq = 1'b1;
    mtx_addr = 10'h3C3;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    outs = {mtx_datack, gpu_datack, ext_datack, ram_cs, ram_we, busy, |ram_sel};
    checkCount++;
    if ({outs, ram_addr} !== 17'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs: ctrl/addr got %b %h expected 0000000 000", outs, ram_addr);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (mtx_datack || busy) acks++;
    end
    checkCount++;
    if (acks != 0) begin
      failCount++;
      $display("[TB] FAIL midreset_held: ack/busy cycles got %0d expected 0", acks);
    end
    reset_n = 1'b1;
    step();
    checkCount++;
    if ({ram_cs, ram_addr} !== {1'b1, 10'h3C3}) begin
      failCount++;
      $display("[TB] FAIL midreset_restart: cs/addr got %b %h expected 1 3c3", ram_cs, ram_addr);
    end
    step();
    checkCount++;
    if (mtx_datack !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midreset_ack: got %b expected 1", mtx_datack);
    end
    mtx_mreq = 1'b0;
    step();
  endtask

  task automatic test_cfg_collision();
    applyReset();
    gpu_mreq = 1'b1;
    gpu_addr = 10'h011;
    cfg_wr   = 1'b1;
    cfg_din  = 2'd2;
    step();
    cfg_wr = 1'b0;
    checkCount++;
    if (ram_cs !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL collide_first_cs: got %b expected 1", ram_cs);
    end
    step();
    checkCount++;
    if ({gpu_datack, ram_cs} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL collide_first_ack: ack/cs got %b expected 10", {gpu_datack, ram_cs});
    end
    step();
    checkCount++;
    if (busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL collide_gap: busy got %b expected 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checkCount++;
      if ({ram_cs, gpu_datack} !== 2'b10) begin
        failCount++;
        $display("[TB] FAIL collide_second_access[%0d]: cs/ack got %b expected 10", i, {ram_cs, gpu_datack});
      end
    end
    step();
    checkCount++;
    if ({gpu_datack, ram_cs} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL collide_second_ack: ack/cs got %b expected 10", {gpu_datack, ram_cs});
    end
    gpu_mreq = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wait_states();
    test_priority();
    test_atomic();
    test_starvation();
    test_reset_mid();
    test_cfg_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  // Absolute backstop so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/j_mtxarb.md
J_MTXARB -- requirements
Module: j_mtxarb

Interface
REQ-001 The block SHALL have exactly one clock; its reset SHALL be asynchronous and active-low, named as follows:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-002 Matrix-fetch requester ports SHALL be:
- mtx_mreq  in  1  matrix operand fetch request, level, held until acknowledged.
- mtx_atomic  in  1  matrix sequence in progress; locks out other requesters.
- mtx_addr  in  10  long-word address.
- mtx_datack  out  1  one-cycle acknowledge.
REQ-003 GPU load/store requester ports SHALL be:
- gpu_mreq  in  1  level request.
- gpu_wr  in  1  1 = write.
- gpu_addr  in  10  long-word address.
- gpu_datack  out  1  one-cycle acknowledge.
REQ-004 External bus requester ports SHALL be:
- ext_mreq  in  1  level request.
- ext_wr  in  1  1 = write.
- ext_addr  in  10  long-word address.
- ext_datack  out  1  one-cycle acknowledge.
REQ-005 Configuration port SHALL be cfg_wr  in  1, with cfg_din  in  2  giving the wait-state count 0-3.
REQ-006 RAM side ports SHALL be:
- ram_cs  out  1  chip select.
- ram_we  out  1  write enable.
- ram_addr  out  10  selected address.
- ram_sel  out  2  data mux select: 0 none, 1 mtx, 2 gpu, 3 ext.
- busy  out  1  FSM not IDLE.

Function
REQ-007 FSM states SHALL be IDLE, ACCESS and ACK.
REQ-008 IDLE transitions:
- Any eligible request -> ACCESS on the next edge, latching the grant, address, wr and the wait count.
- No eligible request -> stay in IDLE.
REQ-009 ACCESS SHALL last 1+W cycles, where W is the wait count latched at grant; it then goes to ACK.
REQ-010 ACK SHALL last exactly one cycle, pulse the granted requester's datack and return to IDLE.
REQ-011 Latency: a request first seen in IDLE at cycle N SHALL receive datack in cycle N+2+W, with no other request in progress.
REQ-012 ram_cs SHALL be 1 throughout ACCESS only.
- ram_we SHALL equal the latched wr during ACCESS (mtx is always a read).
- ram_addr and ram_sel SHALL be stable from ACCESS entry through ACK.
REQ-013 Eligibility: when mtx_atomic=1, only mtx_mreq SHALL be eligible.
REQ-014 Priority with mtx_atomic=0 SHALL be ext > mtx > gpu.
- Exception: when starve=4, gpu SHALL win if requesting.
REQ-015 starve SHALL be a 3-bit saturating counter.
- Increments when gpu_mreq=1 in IDLE and gpu loses.
- Clears when gpu is granted or gpu_mreq=0 in IDLE.
- Saturates at 4.
REQ-016 At most one datack SHALL be high in any cycle; datack is never asserted outside ACK.
REQ-017 A request withdrawn before acknowledge is a protocol error; the access SHALL still complete with datack as normal.
REQ-018 cfg_wr SHALL load the wait register on the next edge.
- An access already granted keeps its latched W.
- cfg_wr in the same IDLE cycle as a grant: the grant SHALL use the old value.
REQ-019 Requests SHALL NOT be re-sampled during ACCESS or ACK.
- Back-to-back accesses therefore have at least one IDLE cycle between ACK and the next ACCESS.

Reset
REQ-020 While reset_n=0, all of the following SHALL hold:
- FSM in IDLE.
- All datack, ram_cs, ram_we and busy at 0.
- ram_sel and ram_addr at 0.
- starve at 0; wait register at 0.
REQ-021 Reset asserted mid-ACCESS SHALL abort the access with no datack issued.
- After reset_n returns high, arbitration SHALL restart from IDLE on the next edge.

Structure
REQ-022 The shared package SHALL hold:
- The FSM state encoding.
- The ram_sel codes (NONE=0, MTX=1, GPU=2, EXT=3).
- The starvation threshold (4).
- The address width (10).
REQ-023 A single sub-module, j_mtxarb_pick, SHALL be used.
- It is a combinational priority/eligibility picker taking the requests, mtx_atomic and starve, and returning a grant code.
- The FSM, wait counter and starve counter SHALL reside in j_mtxarb.

Verification
REQ-024 Single read: W=0, gpu_mreq=1, gpu_addr=0x155 held from IDLE cycle N.
- ram_cs=1 and ram_addr=0x155 in cycle N+1; gpu_datack=1 in N+2 only.
REQ-025 Wait states: cfg W=3, then ext_mreq=1, ext_wr=1.
- ram_cs=1 and ram_we=1 for 4 cycles; ext_datack in cycle N+5.
REQ-026 Atomic lock: mtx_atomic=1 with all three requests high for 3 consecutive accesses.
- Only mtx_datack pulses; ext and gpu receive none until mtx_atomic=0.
REQ-027 Starvation: ext_mreq held high continuously, gpu_mreq held high.
- Grant order: ext, ext, ext, ext, gpu, ext, ...
REQ-028 Reset mid-operation: reset_n=0 during ACCESS with W=2.
- All outputs 0 immediately, no datack issued.
- After release, a pending mtx request is acknowledged at N+2.
REQ-029 Config collision: cfg_wr with cfg_din=2 in the same IDLE cycle as a gpu grant while W=0.
- That access uses 1 ACCESS cycle; the following access uses 3.
